slave_port_arbiter: RTL

- Shares one crossbar slave port between NUM_MASTERS master-side request channels.
- Each master channel is the registered output of that master's request controller: req, cmd, sel, addr, wdata.
- Selects one eligible requester round-robin, forwards its request to the slave, waits for the slave ack, then returns a one-cycle ack (plus read data) to the winning master.
- One instance per slave port.

---
 rtl/xbar_pkg.sv | 22 ++
 rtl/rr_picker.sv | 37 +++
 rtl/slave_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar slave-port arbitration logic.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, RELEASE)
//   idx_w()     : width of a master index, never less than one bit
//   CMD_W/SEL_W : widths of the per-master command and slave-select fields
package xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = idx_w(MAX_MASTERS);
  localparam int CMD_W       = 1;
  localparam int SEL_W       = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   eligible  : one bit per requester
//   ptr       : index where the upward search starts (wraps at N-1 -> 0)
//   any_valid : at least one requester is eligible
//   winner    : index of the first eligible requester at or after ptr
//   winner_oh : one-hot form of winner, all zero when nothing is eligible
module rr_picker
  import xbar_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          any_valid,
  output logic [IW-1:0] winner,
  output logic [N-1:0]  winner_oh
);

  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    winner    = '0;
    winner_oh = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_valid && eligible[idx]) begin
        any_valid      = 1'b1;
        winner         = IW'(idx);
        winner_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Shares one crossbar slave port between NUM_MASTERS request channels.
// A master is eligible when it requests and its sel matches SLAVE_ID; the
// winner is chosen round-robin, its request is latched onto the slave port,
// and the slave's ack is returned one cycle later as a one-hot m_ack pulse
// together with the slave read data.
//   aclk, aresetn                     : clock, synchronous active-low reset
//   m_req/m_cmd/m_sel/m_addr/m_wdata  : packed master request channels
//   m_ack, m_rdata                    : completion pulse and read data
//   s_req/s_cmd/s_addr/s_wdata        : request to the slave
//   s_ack, s_rdata                    : slave completion and read data
//   grant                             : one-hot port owner, 0 when idle
//   busy                              : high while the port is owned
module slave_port_arbiter
  import xbar_pkg::*;
#(
  parameter int   NUM_MASTERS = 2,
  parameter int   AWIDTH      = 32,
  parameter int   DWIDTH      = 32,
  parameter logic SLAVE_ID    = 1'b0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS-1:0]        m_sel,
  input  logic [NUM_MASTERS*AWIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DWIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DWIDTH-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [AWIDTH-1:0]             s_addr,
  output logic [DWIDTH-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DWIDTH-1:0]             s_rdata,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int             IW   = idx_w(NUM_MASTERS);
  localparam logic [IW-1:0]  LAST = IW'(NUM_MASTERS - 1);

  arb_state_e             state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          win_idx;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   pick_cmd;
  logic [AWIDTH-1:0]      pick_addr;
  logic [DWIDTH-1:0]      pick_wdata;

  assign eligible = m_req & ~(m_sel ^ {NUM_MASTERS{SLAVE_ID}});

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .any_valid (pick_valid),
    .winner    (pick_idx),
    .winner_oh (pick_oh)
  );

  // One-hot mux of the winning master's request fields.
  always_comb begin
    pick_cmd   = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        pick_cmd   = m_cmd[i];
        pick_addr  = m_addr[i*AWIDTH +: AWIDTH];
        pick_wdata = m_wdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      win_idx <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      s_req   <= 1'b0;
      s_cmd   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ack   <= '0;
      m_rdata <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant   <= pick_oh;
            win_idx <= pick_idx;
            s_req   <= 1'b1;
            s_cmd   <= pick_cmd;
            s_addr  <= pick_addr;
            s_wdata <= pick_wdata;
            busy    <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        // Slave outputs stay frozen; the winner dropping req does not abort.
        ST_BUSY: begin
          if (s_ack) begin
            s_req   <= 1'b0;
            s_cmd   <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ack   <= grant;
            m_rdata <= s_rdata;
            rr_ptr  <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            state   <= ST_RELEASE;
          end
        end
        // grant is the winner's one-hot, so masking m_req with it isolates
        // the winner's request level without a variable index.
        ST_RELEASE: begin
          if ((m_req & grant) == '0) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
